module_keypad_scan_ctrl: RTL
============================

# module_keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad that feeds operands into the multiplier. Drives one keypad column at a time from an internal 2-bit column sequencer and synchronizes the four row lines. When a key is found it stops the scan and debounces the key, then emits a single-cycle `key_valid` strobe with a 4-bit key code. The operand capture logic downstream consumes that strobe.

## Interface
Parameters:
- `SCAN_DIV`, default 8: cycles each column is driven before advancing; must be ≥ 3.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed for press and for release; must be ≥ 2.

Ports:
- `clk` input, 1 bit: the single system clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-low.
- `scan_en` input, 1 bit: high lets the column sequencer advance; low freezes the current column (the FSM still runs).
- `row_in` input, 4 bits: raw keypad rows, active-high, asynchronous to `clk`.
- `col_out` output, 4 bits: one-hot active-high column drive, bit *i* = column *i*.
- `key_code` output, 4 bits: last accepted key, coded row*4 + col.
- `key_valid` output, 1 bit: one-cycle pulse when a new key is accepted.
- `key_held` output, 1 bit: high while the accepted key remains pressed (PRESSED state).

## Operation
- Row synchronizer: 2-FF per bit; the result is `row_s`. Only `row_s` is used internally.
- Column index `col_idx` is a 2-bit counter; `col_out` = 1 << `col_idx`.
- Dwell counter counts 0..SCAN_DIV-1 per column. At terminal count with `scan_en`=1 in SCAN: dwell clears, `col_idx` increments, and 3 wraps to 0.
- Settle window: `row_s` is ignored during the first 2 dwell cycles after any column change.
- Row priority: if several `row_s` bits are set, the lowest index wins (`row_idx`).

FSM states:
- SCAN (reset state): the column advances as above. When a sample outside the settle window has `row_s` ≠ 0, capture `row_s`, set debounce count to 1, go to DEBOUNCE. The column freezes from that cycle.
- DEBOUNCE: the column is held.
  - `row_s` equal to the captured value: increment the count. When the count reaches DEBOUNCE_CYCLES, go to PRESSED.
  - `row_s` different (including 0): go to SCAN. The dwell restarts at 0 on the same column, and no output changes.
- PRESSED: the column is held. `key_code` is loaded with {`row_idx`, `col_idx`} on entry. `key_valid` = 1 in the entry cycle only. `key_held` = 1 throughout.
  - Each cycle with `row_s`=0 increments the release count; any nonzero cycle clears it.
  - Release count = DEBOUNCE_CYCLES: go to SCAN, advance `col_idx` by 1, clear the dwell.
- `scan_en`=0 only suppresses column advance in SCAN; detection, debounce and release are unaffected.
- `key_code` holds its value until the next accepted key; it is never cleared except by reset.
- Second key pressed while in PRESSED: ignored. No new strobe occurs until release completes.

## Timing
- Reset values: `col_out`=4'b0001, `col_idx`=0, `key_code`=0, `key_valid`=0, `key_held`=0, dwell and debounce counts 0, synchronizer 0, state SCAN.
- Reset asserted mid-operation forces all reset values immediately, with no wait for a clock edge. Release is synchronous to the next rising `clk`.
- `row_in` to `row_s` latency: 2 cycles.
- Press latency: if the first qualifying sample is in cycle T, then `key_valid`=1 and `key_held`=1 in cycle T+DEBOUNCE_CYCLES, and `key_valid`=0 again at T+DEBOUNCE_CYCLES+1.
- Release: if `row_s` first reads 0 in cycle R and stays 0, then `key_held`=0 and the state is SCAN at R+DEBOUNCE_CYCLES. `col_out` shows the next column in that same cycle.
- Free-running scan with `scan_en`=1 and no key: full rotation every 4*SCAN_DIV cycles.
- All outputs are registered; no combinational path from `row_in` to any output.

## Test plan
- Reset, then idle: with `row_in`=0, `col_out` steps 0001→0010→0100→1000→0001, holding each value exactly 8 cycles; `key_valid` never pulses.
- Press row 2 while column 1 is driven, held 20 cycles, then released: one `key_valid` pulse with `key_code`=9 (4'b1001).
  - `key_held` stays high until 4 cycles after `row_s` returns to 0.
  - `col_out` then becomes 0100.
- Bounce: `row_in` toggles between 0100 and 0000 every 2 cycles for 30 cycles. Response: no `key_valid`, `key_code` unchanged, scanning continues.
- Multi-row: `row_in`=1010 stable on column 3. Response: `key_code`=7 (row 1), exactly one strobe.
- `scan_en`=0 at column 2: `col_out` stays 0100 indefinitely. A key on row 0 still produces `key_code`=2 with one strobe.
- Reset asserted mid-DEBOUNCE and again during PRESSED. Response: immediate `col_out`=0001, `key_held`=0, `key_code`=0, and no strobe after reset release while `row_in`=0.

Source files
------------

// File: rtl/module_keypad_scan_ctrl.sv
// Purpose: 4x4 keypad column scanner with row sync, press/release debounce and key strobe.
// Latency: row_in->row_s 2 cycles; key_valid DEBOUNCE_CYCLES cycles after the first qualifying sample.
// Backpressure: none; key_valid is a one-cycle strobe that the consumer must take when it fires.
module module_keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] SETTLE     = DW'(2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      row_m;
  logic [3:0]      row_s;
  logic [3:0]      cap_row;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [DW-1:0]   dwell;
  logic [CW-1:0]   deb_cnt;
  logic [CW-1:0]   rel_cnt;

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m <= 4'b0000;
      row_s <= 4'b0000;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  // Lowest set row of the captured pattern wins when several rows are active.
  always_comb begin
    row_idx = 2'd0;
    if (cap_row[3]) row_idx = 2'd3;
    if (cap_row[2]) row_idx = 2'd2;
    if (cap_row[1]) row_idx = 2'd1;
    if (cap_row[0]) row_idx = 2'd0;
  end

  // Scan / debounce / pressed FSM; col_out is kept as a rotating one-hot alongside col_idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      col_out   <= 4'b0001;
      dwell     <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      cap_row   <= 4'b0000;
      key_code  <= 4'b0000;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          // Rows are only trusted once the column drive has settled for 2 cycles.
          if (dwell >= SETTLE && row_s != 4'b0000) begin
            cap_row <= row_s;
            deb_cnt <= CNT_ONE;
            state   <= ST_DEBOUNCE;
          end else if (dwell == DWELL_LAST) begin
            // With scan_en low the dwell parks at terminal count so the column stays put.
            if (scan_en) begin
              dwell   <= '0;
              col_idx <= col_idx + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end else begin
            dwell <= dwell + DWELL_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == cap_row) begin
            if (deb_cnt == CNT_LAST) begin
              deb_cnt   <= CNT_FULL;
              state     <= ST_PRESSED;
              key_code  <= {row_idx, col_idx};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rel_cnt   <= '0;
            end else begin
              deb_cnt <= deb_cnt + CNT_ONE;
            end
          end else begin
            // Bounce: resume scanning the same column from a fresh dwell.
            state   <= ST_SCAN;
            dwell   <= '0;
            deb_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          if (row_s == 4'b0000) begin
            if (rel_cnt == CNT_LAST) begin
              // Release accepted: move on to the next column regardless of scan_en.
              state    <= ST_SCAN;
              key_held <= 1'b0;
              rel_cnt  <= '0;
              deb_cnt  <= '0;
              dwell    <= '0;
              col_idx  <= col_idx + 2'd1;
              col_out  <= {col_out[2:0], col_out[3]};
            end else begin
              rel_cnt <= rel_cnt + CNT_ONE;
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: begin
          state <= ST_SCAN;
          dwell <= '0;
        end
      endcase
    end
  end

endmodule
